pose_controller: RTL and testbench

POSE_CONTROLLER -- requirements
Module: pose_controller

---
 rtl/pose_pkg.sv | 32 +++
 rtl/pose_axis.sv | 87 ++++++++
 rtl/pose_controller.sv | 153 +++++++++++++++
 tb/tb_pose_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pose_pkg.sv
// Shared constants for the pose controller: HID keycodes, angle modulus, reset z, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pose_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_Q     = 8'h14;
    localparam logic [7:0] KEY_E     = 8'h08;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_X     = 8'h1B;
    localparam logic [7:0] KEY_R     = 8'h15;

    localparam logic [11:0] TWO_PI = 12'h648;
    // Reset z (-4.0) for the default 8.8 position format.
    localparam logic [15:0] Z_INIT = 16'hFC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEL,
        ST_ANG,
        ST_POS,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pose_axis.sv
// pose_axis: velocity + angle of one rotation axis; POSE_CTRL_MOMENTUM_EN adds velocity state.
// Latency: velocity updates on vel_en, angle on ang_en, each at the following edge.
// Backpressure: none; strobes are one-cycle commands from the controller FSM.
module pose_axis
    import pose_pkg::*;
#(
    parameter int              AW       = 12,
    parameter logic [AW-1:0]   V_MAX    = 12'h010,
    parameter logic [AW-1:0]   FRICTION = 12'h002
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vel_en,
    input  logic          ang_en,
    input  logic          clr,
    input  logic [AW-1:0] accel,
    output logic [AW-1:0] angle
);

    localparam logic signed [AW:0] TWO_PI_S = $signed({1'b0, AW'(TWO_PI)});

    logic [AW-1:0] v_eff;
    logic [AW-1:0] angle_q, angle_d;
    logic signed [AW:0] s;

`ifdef POSE_CTRL_MOMENTUM_EN
    localparam logic signed [AW:0] VMAX_S = $signed({1'b0, V_MAX});
    localparam logic signed [AW:0] FRIC_S = $signed({1'b0, FRICTION});

    logic [AW-1:0] vel_q, vel_d;
    logic signed [AW:0] vext, aext, vsum;

    always_comb begin
        vel_d = vel_q;
        vext  = {vel_q[AW-1], vel_q};
        aext  = {accel[AW-1], accel};
        vsum  = vext + aext;
        if (clr) begin
            vel_d = '0;
        end else if (vel_en) begin
            if (accel != '0) begin
                if (vsum > VMAX_S)       vel_d = V_MAX;
                else if (vsum < -VMAX_S) vel_d = -V_MAX;
                else                     vel_d = vsum[AW-1:0];
            end else if (vext > FRIC_S) begin
                vel_d = vel_q - FRICTION;
            end else if (vext < -FRIC_S) begin
                vel_d = vel_q + FRICTION;
            end else begin
                vel_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) vel_q <= '0;
        else          vel_q <= vel_d;
    end

    assign v_eff = vel_q;
`else
    // Without momentum the rotation rate is just this frame's acceleration.
    logic vel_unused;
    assign vel_unused = vel_en ^ (^V_MAX) ^ (^FRICTION);
    assign v_eff      = accel;
`endif

    always_comb begin
        angle_d = angle_q;
        s       = $signed({1'b0, angle_q}) + $signed({v_eff[AW-1], v_eff});
        if (clr) begin
            angle_d = '0;
        end else if (ang_en) begin
            if (s >= TWO_PI_S)  angle_d = AW'(s - TWO_PI_S);
            else if (s[AW])     angle_d = AW'(s + TWO_PI_S);
            else                angle_d = s[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) angle_q <= '0;
        else          angle_q <= angle_d;
    end

    assign angle = angle_q;

endmodule

// File: rtl/pose_controller.sv
// pose_controller: per-frame 3-D pose update from a HID keycode; POSE_CTRL_MOMENTUM_EN enables angular momentum.
// Latency: frame tick in cycle t -> refreshed outputs with update_done in cycle t+4.
// Backpressure: none; ticks arriving while busy are dropped and flagged on sticky overrun.
module pose_controller
    import pose_pkg::*;
#(
    parameter int                 WI       = 8,
    parameter int                 WF       = 8,
    parameter int                 AW       = 12,
    parameter logic [WI+WF-1:0]   POS_STEP = 16'h0200,
    parameter logic [WI+WF-1:0]   POS_LIM  = 16'h7000,
    parameter logic [AW-1:0]      V_MAX    = 12'h010,
    parameter logic [AW-1:0]      A_STEP   = 12'h004,
    parameter logic [AW-1:0]      FRICTION = 12'h002
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk_rising_edge,
    input  logic [7:0]         keycode,
    output logic [AW-1:0]      alpha,
    output logic [AW-1:0]      beta,
    output logic [AW-1:0]      gamma,
    output logic [WI+WF-1:0]   x,
    output logic [WI+WF-1:0]   y,
    output logic [WI+WF-1:0]   z,
    output logic               update_done,
    output logic               overrun
);

    localparam int PW = WI + WF;
    localparam logic [PW-1:0]      Z_RST  = PW'(-(4 << WF));
    localparam logic signed [PW:0] STEP_S = $signed({1'b0, POS_STEP});
    localparam logic signed [PW:0] LIM_S  = $signed({1'b0, POS_LIM});

    state_e state_q, state_d;
    logic [7:0]    key_q, key_d;
    logic          overrun_q, overrun_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic          vel_en, ang_en, pos_en;
    logic          recenter;
    logic [AW-1:0] acc_alpha, acc_beta, acc_gamma;

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (frame_clk_rising_edge) state_d = ST_VEL;
            ST_VEL:  state_d = ST_ANG;
            ST_ANG:  state_d = ST_POS;
            ST_POS:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vel_en      = 1'b0;
        ang_en      = 1'b0;
        pos_en      = 1'b0;
        update_done = 1'b0;
        unique case (state_q)
            ST_VEL:  vel_en      = 1'b1;
            ST_ANG:  ang_en      = 1'b1;
            ST_POS:  pos_en      = 1'b1;
            ST_DONE: update_done = 1'b1;
            default: ;
        endcase
    end

    // The keycode is only meaningful on the accepted tick; later changes are ignored.
    always_comb begin
        key_d     = key_q;
        overrun_d = overrun_q;
        if (frame_clk_rising_edge) begin
            if (state_q == ST_IDLE) key_d     = keycode;
            else                    overrun_d = 1'b1;
        end
    end

    assign recenter  = (key_q == KEY_R);
    assign acc_alpha = (key_q == KEY_Q) ? A_STEP : (key_q == KEY_E) ? -A_STEP : '0;
    assign acc_beta  = (key_q == KEY_W) ? A_STEP : (key_q == KEY_S) ? -A_STEP : '0;
    assign acc_gamma = (key_q == KEY_A) ? A_STEP : (key_q == KEY_D) ? -A_STEP : '0;

    function automatic logic [PW-1:0] pos_move(input logic [PW-1:0] p,
                                               input logic up, input logic dn);
        logic signed [PW:0] s;
        s = {p[PW-1], p};
        if (up)      s = s + STEP_S;
        else if (dn) s = s - STEP_S;
        if (s > LIM_S)       s = LIM_S;
        else if (s < -LIM_S) s = -LIM_S;
        return s[PW-1:0];
    endfunction

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (pos_en) begin
            if (recenter) begin
                x_d = '0;
                y_d = '0;
                z_d = Z_RST;
            end else begin
                x_d = pos_move(x_q, key_q == KEY_RIGHT, key_q == KEY_LEFT);
                y_d = pos_move(y_q, key_q == KEY_Z,     key_q == KEY_X);
                z_d = pos_move(z_q, key_q == KEY_UP,    key_q == KEY_DOWN);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            key_q     <= '0;
            overrun_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= Z_RST;
        end else begin
            key_q     <= key_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
        end
    end

    pose_axis #(.AW(AW), .V_MAX(V_MAX), .FRICTION(FRICTION)) u_axis_alpha (
        .clk(Clk), .reset_n(Reset_n), .vel_en(vel_en), .ang_en(ang_en),
        .clr(pos_en & recenter), .accel(acc_alpha), .angle(alpha)
    );

    pose_axis #(.AW(AW), .V_MAX(V_MAX), .FRICTION(FRICTION)) u_axis_beta (
        .clk(Clk), .reset_n(Reset_n), .vel_en(vel_en), .ang_en(ang_en),
        .clr(pos_en & recenter), .accel(acc_beta), .angle(beta)
    );

    pose_axis #(.AW(AW), .V_MAX(V_MAX), .FRICTION(FRICTION)) u_axis_gamma (
        .clk(Clk), .reset_n(Reset_n), .vel_en(vel_en), .ang_en(ang_en),
        .clr(pos_en & recenter), .accel(acc_gamma), .angle(gamma)
    );

    assign x       = x_q;
    assign y       = y_q;
    assign z       = z_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pose_controller.sv
// Bench for pose_controller: randomized keycode frames checked against an integer pose model.
module tb_pose_controller;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk_rising_edge;
    logic [7:0]  keycode;
    logic [11:0] alpha, beta, gamma;
    logic [15:0] x, y, z;
    logic        update_done, overrun;

    int total = 0;
    int bad   = 0;
    int m_ang[3];
    int m_vel[3];
    int m_pos[3];
    logic [3:0] done_pat;

    localparam logic [83:0] RST_VEC = {12'h000, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'hFC00};

    always #5 Clk = ~Clk;

    pose_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk_rising_edge(frame_clk_rising_edge),
        .keycode(keycode), .alpha(alpha), .beta(beta), .gamma(gamma),
        .x(x), .y(y), .z(z), .update_done(update_done), .overrun(overrun)
    );

    function automatic int clampi(input int v, input int lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ang[i] = 0;
            m_vel[i] = 0;
            m_pos[i] = 0;
        end
        m_pos[2] = -1024;
    endfunction

    // Integer pose model: angles in 1/256 rad units modulo 0x648, positions in 8.8.
    function automatic void model_frame(input logic [7:0] key);
        int acc[3] = '{0, 0, 0};
        int dp[3]  = '{0, 0, 0};
        case (key)
            8'h14: acc[0] = 4;    8'h08: acc[0] = -4;
            8'h1A: acc[1] = 4;    8'h16: acc[1] = -4;
            8'h04: acc[2] = 4;    8'h07: acc[2] = -4;
            8'h4F: dp[0] = 512;   8'h50: dp[0] = -512;
            8'h1D: dp[1] = 512;   8'h1B: dp[1] = -512;
            8'h52: dp[2] = 512;   8'h51: dp[2] = -512;
            default: ;
        endcase
        for (int i = 0; i < 3; i++) begin
`ifdef POSE_CTRL_MOMENTUM_EN
            if (acc[i] != 0)          m_vel[i] = clampi(m_vel[i] + acc[i], 16);
            else if (m_vel[i] > 2)    m_vel[i] = m_vel[i] - 2;
            else if (m_vel[i] < -2)   m_vel[i] = m_vel[i] + 2;
            else                      m_vel[i] = 0;
`else
            m_vel[i] = acc[i];
`endif
            m_ang[i] = (m_ang[i] + m_vel[i] + 1608) % 1608;
            m_pos[i] = clampi(m_pos[i] + dp[i], 28672);
        end
        if (key == 8'h15) model_reset();
    endfunction

    function automatic logic [83:0] exp_vec();
        return {12'(m_ang[0]), 12'(m_ang[1]), 12'(m_ang[2]),
                16'(m_pos[0]), 16'(m_pos[1]), 16'(m_pos[2])};
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_clk_rising_edge = 1'b0;
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
    endtask

    // Issues one tick, records update_done at the four following negedges, returns in DONE.
    task automatic do_frame(input logic [7:0] key);
        @(negedge Clk);
        keycode = key;
        frame_clk_rising_edge = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            frame_clk_rising_edge = 1'b0;
            keycode = 8'($urandom);
            done_pat[k] = update_done;
        end
        model_frame(key);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_clk_rising_edge = 1'b0;
        keycode = 8'h00;
        repeat (3) @(negedge Clk);
        total++;
        if ({alpha, beta, gamma, x, y, z} !== RST_VEC) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", {alpha, beta, gamma, x, y, z}, RST_VEC);
        end
        total++;
        if ({update_done, overrun} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b exp=00", {update_done, overrun});
        end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_tick();
        do_reset();
        do_frame(8'h00);
        total++;
        if (done_pat !== 4'b1000) begin
            bad++; $display("FAIL idle_tick_latency got=%b exp=1000", done_pat);
        end
        total++;
        if ({alpha, beta, gamma, x, y, z} !== RST_VEC || overrun !== 1'b0) begin
            bad++; $display("FAIL idle_tick_values got=%h ovr=%b exp=%h ovr=0",
                            {alpha, beta, gamma, x, y, z}, overrun, RST_VEC);
        end
        @(negedge Clk);
        total++;
        if (update_done !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width got=%b exp=0", update_done);
        end
    endtask

    task automatic test_rotation();
`ifdef POSE_CTRL_MOMENTUM_EN
        logic [7:0]  keys [15] = '{8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [11:0] tab  [15] = '{12'h004, 12'h00C, 12'h018, 12'h028, 12'h038, 12'h046, 12'h052,
                                   12'h05C, 12'h064, 12'h06A, 12'h06E, 12'h070, 12'h070, 12'h070, 12'h070};
        do_reset();
        for (int f = 0; f < 15; f++) begin
            do_frame(keys[f]);
            total++;
            if (beta !== tab[f]) begin
                bad++; $display("FAIL momentum_beta f=%0d got=%h exp=%h", f, beta, tab[f]);
            end
        end
`else
        logic [7:0]  keys [4] = '{8'h04, 8'h04, 8'h04, 8'h00};
        logic [11:0] tab  [4] = '{12'h004, 12'h008, 12'h00C, 12'h00C};
        do_reset();
        for (int f = 0; f < 4; f++) begin
            do_frame(keys[f]);
            total++;
            if (gamma !== tab[f]) begin
                bad++; $display("FAIL step_gamma f=%0d got=%h exp=%h", f, gamma, tab[f]);
            end
        end
`endif
        total++;
        if ({alpha, beta, gamma, x, y, z} !== exp_vec()) begin
            bad++; $display("FAIL rotation_model got=%h exp=%h", {alpha, beta, gamma, x, y, z}, exp_vec());
        end
    endtask

    task automatic test_wrap();
        int wraps;
        logic [11:0] prev;
        do_reset();
        wraps = 0;
        for (int f = 0; f < 840; f++) begin
            prev = beta;
            do_frame(f < 420 ? 8'h1A : 8'h16);
            if ((f < 420 && beta < prev) || (f >= 420 && beta > prev)) wraps++;
            total++;
            if (beta !== 12'(m_ang[1])) begin
                bad++; $display("FAIL wrap_beta f=%0d got=%h exp=%h", f, beta, 12'(m_ang[1]));
            end
            total++;
            if (beta >= 12'h648) begin
                bad++; $display("FAIL wrap_range f=%0d got=%h exp=<648", f, beta);
            end
        end
        total++;
        if (wraps < 2) begin
            bad++; $display("FAIL wrap_seen got=%0d exp=>=2", wraps);
        end
    endtask

    task automatic test_pos_sat();
        int ze;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            do_frame(8'h52);
            ze = -1024 + 512 * k;
            if (ze > 28672) ze = 28672;
            total++;
            if ({x, y, z} !== {16'h0000, 16'h0000, 16'(ze)}) begin
                bad++; $display("FAIL pos_up k=%0d got=%h exp=%h", k, z, 16'(ze));
            end
        end
        for (int k = 1; k <= 120; k++) begin
            do_frame(8'h51);
            ze = 28672 - 512 * k;
            if (ze < -28672) ze = -28672;
            total++;
            if (z !== 16'(ze)) begin
                bad++; $display("FAIL pos_down k=%0d got=%h exp=%h", k, z, 16'(ze));
            end
        end
    endtask

    task automatic test_overrun();
        int pulses;
        do_reset();
        @(negedge Clk); keycode = 8'h14; frame_clk_rising_edge = 1'b1;
        @(negedge Clk); keycode = 8'h1A; frame_clk_rising_edge = 1'b0;
        @(negedge Clk);
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_early got=%b exp=0", overrun);
        end
        frame_clk_rising_edge = 1'b1;
        @(negedge Clk); frame_clk_rising_edge = 1'b0;
        total++;
        if (update_done !== 1'b0) begin
            bad++; $display("FAIL overrun_done_early got=%b exp=0", update_done);
        end
        @(negedge Clk);
        model_frame(8'h14);
        total++;
        if ({update_done, overrun} !== 2'b11) begin
            bad++; $display("FAIL overrun_flags got=%b exp=11", {update_done, overrun});
        end
        total++;
        if ({alpha, beta, gamma, x, y, z} !== exp_vec()) begin
            bad++; $display("FAIL overrun_first_key got=%h exp=%h", {alpha, beta, gamma, x, y, z}, exp_vec());
        end
        pulses = 0;
        repeat (8) begin
            @(negedge Clk);
            if (update_done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL overrun_extra_done got=%0d exp=0", pulses);
        end
        total++;
        if ({alpha, beta, gamma, x, y, z} !== exp_vec() || overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_hold got=%h ovr=%b exp=%h ovr=1",
                            {alpha, beta, gamma, x, y, z}, overrun, exp_vec());
        end
    endtask

    task automatic test_abort();
        int pulses;
        do_reset();
        @(negedge Clk); keycode = 8'h52; frame_clk_rising_edge = 1'b1;
        @(negedge Clk); frame_clk_rising_edge = 1'b0;
        @(negedge Clk); Reset_n = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge Clk);
            if (update_done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL abort_done got=%0d exp=0", pulses);
        end
        total++;
        if ({alpha, beta, gamma, x, y, z} !== RST_VEC) begin
            bad++; $display("FAIL abort_outputs got=%h exp=%h", {alpha, beta, gamma, x, y, z}, RST_VEC);
        end
    endtask

    task automatic test_recenter();
        logic [7:0] keys [8] = '{8'h1A, 8'h1A, 8'h14, 8'h04, 8'h52, 8'h4F, 8'h1D, 8'h1A};
        do_reset();
        foreach (keys[i]) do_frame(keys[i]);
        do_frame(8'h15);
        total++;
        if ({alpha, beta, gamma, x, y, z} !== RST_VEC) begin
            bad++; $display("FAIL recenter got=%h exp=%h", {alpha, beta, gamma, x, y, z}, RST_VEC);
        end
        do_frame(8'h00);
        total++;
        if ({alpha, beta, gamma, x, y, z} !== RST_VEC) begin
            bad++; $display("FAIL recenter_vel got=%h exp=%h", {alpha, beta, gamma, x, y, z}, RST_VEC);
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [14] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h14, 8'h08, 8'h52,
                                  8'h51, 8'h50, 8'h4F, 8'h1D, 8'h1B, 8'h15, 8'h00};
        logic [7:0] key;
        int run;
        do_reset();
        run = 0;
        key = 8'h00;
        for (int f = 0; f < 300; f++) begin
            if (run == 0) begin
                key = ($urandom_range(0, 4) == 0) ? 8'($urandom) : keys[$urandom_range(0, 13)];
                run = $urandom_range(1, 25);
            end
            do_frame(key);
            run--;
            total++;
            if (done_pat !== 4'b1000) begin
                bad++; $display("FAIL rand_latency f=%0d got=%b exp=1000", f, done_pat);
            end
            total++;
            if ({alpha, beta, gamma, x, y, z} !== exp_vec()) begin
                bad++; $display("FAIL rand_pose f=%0d key=%h got=%h exp=%h",
                                f, key, {alpha, beta, gamma, x, y, z}, exp_vec());
            end
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL rand_overrun got=%b exp=0", overrun);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        frame_clk_rising_edge = 1'b0;
        keycode = 8'h00;
        done_pat = '0;
        test_reset();
        test_idle_tick();
        test_rotation();
        test_wrap();
        test_pos_sat();
        test_overrun();
        test_reset();
        test_abort();
        test_recenter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
